// File: rtl/arp_tx_scheduler.sv
// ARP transmit scheduler: arbitrates reply jobs and resolution requests onto the
// ARP frame transmitter, and owns the retransmit timer / retry budget for requests.
module arp_tx_scheduler #(
   parameter int unsigned RETRY_CYCLES = 125000000,
   parameter int unsigned MAX_RETRIES  = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rep_req,
   input  logic [47:0] rep_mac,
   input  logic [31:0] rep_ip,
   input  logic        res_req,
   input  logic [31:0] res_ip,
   input  logic        res_done,
   output logic        res_fail,
   output logic        res_busy,
   output logic        tx_start,
   input  logic        tx_eop,
   output logic [47:0] tx_mac_dst,
   output logic [15:0] tx_oper,
   output logic [47:0] tx_tha,
   output logic [31:0] tx_tpa,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
   typedef enum logic {SEL_REPLY, SEL_REQ} sel_t;
   typedef struct packed {
      logic [47:0] mac_dst;
      logic [15:0] oper;
      logic [47:0] tha;
      logic [31:0] tpa;
   } tx_fields_t;

   state_t     state, state_nxt;
   sel_t       sel, sel_nxt;
   logic       load;
   tx_fields_t fields;

   logic        rep_valid;
   logic [47:0] rep_mac_q;
   logic [31:0] rep_ip_q;

   logic        res_pend;
   logic [31:0] res_ip_q;
   logic [31:0] retry_cnt;
   logic [31:0] timer;
   logic        accept, expire, exhausted, eop_req;

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      load      = 1'b0;
      tx_start  = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (rep_valid) begin
               state_nxt = LAUNCH;
               sel_nxt   = SEL_REPLY;
               load      = 1'b1;
            end else if (res_pend) begin
               state_nxt = LAUNCH;
               sel_nxt   = SEL_REQ;
               load      = 1'b1;
            end
         end
         LAUNCH: begin
            tx_start  = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (tx_eop) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sel    <= SEL_REPLY;
         fields <= '0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         if (load) begin
            if (sel_nxt == SEL_REPLY)
               fields <= '{mac_dst: rep_mac_q, oper: 16'h0002, tha: rep_mac_q, tpa: rep_ip_q};
            else
               fields <= '{mac_dst: 48'hFFFF_FFFF_FFFF, oper: 16'h0001, tha: 48'h0, tpa: res_ip_q};
         end
      end
   end

   assign tx_mac_dst = fields.mac_dst;
   assign tx_oper    = fields.oper;
   assign tx_tha     = fields.tha;
   assign tx_tpa     = fields.tpa;

   // Pending flags drop as the fields are captured, so a job arriving during
   // the launch cycle itself is kept rather than lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_valid <= 1'b0;
         rep_mac_q <= '0;
         rep_ip_q  <= '0;
      end else if (rep_req) begin
         rep_valid <= 1'b1;
         rep_mac_q <= rep_mac;
         rep_ip_q  <= rep_ip;
      end else if (load && sel_nxt == SEL_REPLY) begin
         rep_valid <= 1'b0;
      end
   end

   assign accept    = res_req && (!res_busy || res_done);
   assign expire    = res_busy && (timer == 32'd1) && !res_done;
   assign exhausted = (retry_cnt >= MAX_RETRIES);
   assign eop_req   = (state == WAIT) && tx_eop && (sel == SEL_REQ);
   assign res_fail  = expire && exhausted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_busy  <= 1'b0;
         res_pend  <= 1'b0;
         res_ip_q  <= '0;
         retry_cnt <= '0;
         timer     <= '0;
      end else begin
         if (res_done) begin
            res_busy <= 1'b0;
            res_pend <= 1'b0;
            timer    <= '0;
         end else begin
            if (load && sel_nxt == SEL_REQ) res_pend <= 1'b0;
            if (eop_req && res_busy)
               timer <= 32'(RETRY_CYCLES);
            else if (res_busy && timer != 32'd0)
               timer <= timer - 32'd1;
            if (expire) begin
               if (!exhausted) begin
                  retry_cnt <= retry_cnt + 32'd1;
                  res_pend  <= 1'b1;
               end else begin
                  res_busy <= 1'b0;
               end
            end
         end
         // A same-cycle res_done has already freed the slot, so the new request lands.
         if (accept) begin
            res_busy  <= 1'b1;
            res_pend  <= 1'b1;
            res_ip_q  <= res_ip;
            retry_cnt <= '0;
            timer     <= '0;
         end
      end
   end

endmodule

// File: tb/tb_arp_tx_scheduler.sv
// Directed bench for arp_tx_scheduler: reply path, priority, retry/fail timing,
// early resolution, reply overwrite, ignored duplicate request, async reset.
module tb_arp_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rep_req, res_req, res_done, tx_eop;
   logic [47:0] rep_mac;
   logic [31:0] rep_ip, res_ip;
   logic        res_fail, res_busy, tx_start, busy;
   logic [47:0] tx_mac_dst, tx_tha;
   logic [15:0] tx_oper;
   logic [31:0] tx_tpa;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   arp_tx_scheduler #(.RETRY_CYCLES(100), .MAX_RETRIES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .rep_req(rep_req), .rep_mac(rep_mac), .rep_ip(rep_ip),
      .res_req(res_req), .res_ip(res_ip), .res_done(res_done),
      .res_fail(res_fail), .res_busy(res_busy),
      .tx_start(tx_start), .tx_eop(tx_eop),
      .tx_mac_dst(tx_mac_dst), .tx_oper(tx_oper), .tx_tha(tx_tha), .tx_tpa(tx_tpa),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_eop(output int m);
      tx_eop = 1'b1;
      m = cyc;
      step();
      tx_eop = 1'b0;
   endtask

   task automatic wait_tx(input string tag, input int max, output int at);
      at = -1;
      for (int i = 0; i < max; i++) begin
         if (tx_start === 1'b1) begin
            at = cyc;
            break;
         end
         step();
      end
      if (at < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no tx_start within %0d cycles", tag, max);
      end
   endtask

   task automatic wait_fail(input int max, output int at, output int starts);
      at = -1;
      starts = 0;
      for (int i = 0; i < max; i++) begin
         if (res_fail === 1'b1) begin
            at = cyc;
            break;
         end
         if (tx_start === 1'b1) starts++;
         step();
      end
   endtask

   task automatic quiet(input int n, output int events);
      events = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (tx_start === 1'b1 || res_fail === 1'b1) events++;
      end
   endtask

   initial begin
      int m, at, ev, st;
      rst_n = 1'b0; rep_req = 1'b0; res_req = 1'b0; res_done = 1'b0; tx_eop = 1'b0;
      rep_mac = '0; rep_ip = '0; res_ip = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_start", tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_busy", res_busy, 0);
      chk("rst_res_fail", res_fail, 0);
      chk("rst_mac_dst", tx_mac_dst, 0);
      chk("rst_oper", tx_oper, 0);
      chk("rst_tha", tx_tha, 0);
      chk("rst_tpa", tx_tpa, 0);
      rst_n = 1'b1;
      step();

      // reply frame, two-cycle latency
      rep_mac = 48'h0011_2233_4455; rep_ip = 32'hC0A8_0102; rep_req = 1'b1;
      step();
      rep_req = 1'b0;
      chk("rep_lat_n1", tx_start, 0);
      step();
      chk("rep_start", tx_start, 1);
      chk("rep_oper", tx_oper, 16'h0002);
      chk("rep_dst", tx_mac_dst, 48'h0011_2233_4455);
      chk("rep_tha", tx_tha, 48'h0011_2233_4455);
      chk("rep_tpa", tx_tpa, 32'hC0A8_0102);
      step();
      chk("rep_busy", busy, 1);
      step(); step();
      chk("rep_busy_hold", busy, 1);
      chk("rep_tpa_hold", tx_tpa, 32'hC0A8_0102);
      do_eop(m);
      chk("rep_idle", busy, 0);
      tx_eop = 1'b1;   // eop outside WAIT must do nothing
      step();
      tx_eop = 1'b0;
      chk("rep_no_relaunch", tx_start, 0);

      // priority, then retry chain to failure
      res_ip = 32'h0A00_0001; res_req = 1'b1;
      rep_mac = 48'hAABB_CCDD_EEFF; rep_ip = 32'hC0A8_0103; rep_req = 1'b1;
      step();
      res_req = 1'b0; rep_req = 1'b0;
      chk("pri_res_busy", res_busy, 1);
      step();
      chk("pri_start", tx_start, 1);
      chk("pri_reply_first", tx_oper, 16'h0002);
      chk("pri_reply_tpa", tx_tpa, 32'hC0A8_0103);
      step();
      do_eop(m);
      wait_tx("req1", 10, at);
      chk("req1_at", at, m + 2);
      chk("req1_oper", tx_oper, 16'h0001);
      chk("req1_dst", tx_mac_dst, 48'hFFFF_FFFF_FFFF);
      chk("req1_tha", tx_tha, 48'h0);
      chk("req1_tpa", tx_tpa, 32'h0A00_0001);
      step();
      do_eop(m);
      wait_tx("retry1", 200, at);
      chk("retry1_at", at, m + 102);
      chk("retry1_tpa", tx_tpa, 32'h0A00_0001);
      step();
      do_eop(m);
      wait_tx("retry2", 200, at);
      chk("retry2_at", at, m + 102);
      step();
      do_eop(m);
      wait_fail(200, at, st);
      chk("fail_at", at, m + 100);
      chk("fail_no_extra_tx", st, 0);
      step();
      chk("fail_res_busy", res_busy, 0);
      chk("fail_pulse_once", res_fail, 0);

      // resolution satisfied mid-wait
      res_ip = 32'h0A00_0002; res_req = 1'b1;
      step();
      res_req = 1'b0;
      step();
      chk("ok_start", tx_start, 1);
      chk("ok_tpa", tx_tpa, 32'h0A00_0002);
      step();
      do_eop(m);
      while (cyc < m + 50) step();
      res_done = 1'b1;
      step();
      res_done = 1'b0;
      chk("ok_res_busy", res_busy, 0);
      quiet(110, ev);
      chk("ok_no_retry_or_fail", ev, 0);

      // new request accepted, then reply overwrite and ignored res_req during WAIT
      res_ip = 32'h0A00_0003; res_req = 1'b1;
      step();
      res_req = 1'b0;
      chk("new_res_busy", res_busy, 1);
      step();
      chk("new_start", tx_start, 1);
      chk("new_tpa", tx_tpa, 32'h0A00_0003);
      step();
      rep_mac = 48'h0200_0000_000A; rep_ip = 32'hC0A8_000A; rep_req = 1'b1;
      step();
      rep_mac = 48'h0200_0000_000B; rep_ip = 32'hC0A8_000B;
      step();
      rep_req = 1'b0;
      res_ip = 32'h0A00_0009; res_req = 1'b1;
      step();
      res_req = 1'b0;
      chk("ovr_tpa_held", tx_tpa, 32'h0A00_0003);
      chk("ovr_busy", busy, 1);
      do_eop(m);
      wait_tx("ovr_reply", 10, at);
      chk("ovr_at", at, m + 2);
      chk("ovr_tpa_b", tx_tpa, 32'hC0A8_000B);
      chk("ovr_dst_b", tx_mac_dst, 48'h0200_0000_000B);
      chk("ovr_oper", tx_oper, 16'h0002);
      step();
      do_eop(m);
      quiet(20, ev);
      chk("ovr_no_extra", ev, 0);
      res_done = 1'b1;
      step();
      res_done = 1'b0;
      chk("ovr_done_busy", res_busy, 0);

      // async reset in WAIT with a request still queued
      rep_mac = 48'h0011_2233_4466; rep_ip = 32'hC0A8_0104; rep_req = 1'b1;
      res_ip = 32'h0A00_0004; res_req = 1'b1;
      step();
      rep_req = 1'b0; res_req = 1'b0;
      step();
      chk("rst2_start", tx_start, 1);
      step();
      chk("rst2_busy_pre", busy, 1);
      chk("rst2_res_busy_pre", res_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst2_busy", busy, 0);
      chk("rst2_tx_start", tx_start, 0);
      chk("rst2_res_busy", res_busy, 0);
      chk("rst2_oper", tx_oper, 0);
      chk("rst2_dst", tx_mac_dst, 0);
      chk("rst2_tpa", tx_tpa, 0);
      step(); step();
      rst_n = 1'b1;
      quiet(10, ev);
      chk("rst2_no_start", ev, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/arp_tx_scheduler.md
# arp_tx_scheduler

Controller that sequences the ARP frame transmitter in the 1G Ethernet stack. Arbitrates between ARP reply jobs raised by the ARP receive path and address-resolution requests raised by the IP layer, drives the transmitter's start pulse and per-frame fields, and waits for frame completion. Also owns the retransmit timer and retry count for outstanding resolution requests, and reports failure when retries are exhausted.

## Interface
- RETRY_CYCLES, 125000000: clk cycles between a request frame's eop and its retransmission (1 s at 125 MHz).
- MAX_RETRIES, 3: retransmissions after the first request; total attempts = 1 + MAX_RETRIES.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rep_req  in  1  one-cycle pulse: send ARP reply.
- rep_mac  in  48  requester MAC, valid with rep_req.
- rep_ip  in  32  requester IP, valid with rep_req.
- res_req  in  1  one-cycle pulse: resolve res_ip.
- res_ip  in  32  IP to resolve, valid with res_req.
- res_done  in  1  pulse: pending resolution satisfied (reply received).
- res_fail  out  1  one-cycle pulse: retries exhausted.
- res_busy  out  1  resolution slot occupied.
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_eop  in  1  transmitter end-of-frame (last word read).
- tx_mac_dst  out  48  Ethernet destination.
- tx_oper  out  16  ARP operation code.
- tx_tha  out  48  target hardware address.
- tx_tpa  out  32  target protocol address.
- busy  out  1  frame launched and not yet completed.

## Operation
- Reply slot: single entry. rep_req sets rep_valid and captures rep_mac/rep_ip. A rep_req while the slot is still valid overwrites it (latest wins). The slot clears when its frame is launched.
- Resolution slot: single entry.
  - res_req while the slot is idle captures res_ip, sets res_busy and res_pend (frame due), and clears retry_cnt.
  - res_req while res_busy is ignored.
  - res_done clears res_busy, res_pend and the timer at any time, including mid-frame; the frame in flight still completes.
- FSM states:
  - IDLE: if rep_valid, go to LAUNCH with sel=REPLY. Otherwise, if res_pend, go to LAUNCH with sel=REQ. Replies always have priority.
  - LAUNCH: one cycle. tx_start=1. Clear the selected pending flag. Go to WAIT.
  - WAIT: busy=1. On tx_eop go to IDLE. If sel=REQ and res_busy, load the timer with RETRY_CYCLES.
- Field registers are loaded on entry to LAUNCH and held until the next LAUNCH.
  - REPLY: tx_mac_dst=rep_mac, tx_oper=16'h0002, tx_tha=rep_mac, tx_tpa=rep_ip.
  - REQ: tx_mac_dst=48'hFFFF_FFFF_FFFF, tx_oper=16'h0001, tx_tha=48'h0, tx_tpa=res_ip.
  - Sender fields, hardware/protocol types and EtherType are tied at top level and are outside this block.
- Timer: 32-bit down-counter, runs only while res_busy and nonzero. On the decrement to zero:
  - if retry_cnt < MAX_RETRIES: retry_cnt++ and set res_pend;
  - else: pulse res_fail and clear res_busy.
- Reset: all flags, counters and FSM are cleared immediately. A frame in flight is abandoned; the transmitter shares rst_n.

## Timing
- Reset values: tx_start=0, busy=0, res_busy=0, res_fail=0, tx_mac_dst=0, tx_oper=0, tx_tha=0, tx_tpa=0; FSM=IDLE.
- Latency: a rep_req or res_req in cycle N with the FSM IDLE and no other work gives tx_start high in cycle N+2.
- Field outputs are valid in the same cycle as tx_start and stable through WAIT.
- tx_eop in cycle M gives IDLE in M+1; the earliest next tx_start is M+2.
- tx_eop outside WAIT is ignored.
- res_done and timer expiry in the same cycle: res_done wins; no res_fail, no retry.
- res_done and res_req in the same cycle: clear first, then accept the new request.
- Retransmit spacing: tx_eop of a request in cycle M gives expiry at M+RETRY_CYCLES.
  - If the FSM is IDLE then, tx_start occurs at M+RETRY_CYCLES+2.
  - If the FSM is busy with a reply, the retry launch is delayed until the FSM returns to IDLE.
- res_fail occurs RETRY_CYCLES after the eop of the final attempt.

## Test plan
Bench parameters: RETRY_CYCLES=100, MAX_RETRIES=2.
- Reply: rep_req with rep_mac=00:11:22:33:44:55, rep_ip=C0A8_0102 -> tx_start 2 cycles later; tx_oper=0002, tx_mac_dst=tx_tha=001122334455, tx_tpa=C0A80102; busy until tx_eop.
- Priority: res_req(0A000001) and rep_req in the same cycle -> reply frame first; request frame (dst FFFFFFFFFFFF, oper 0001, tha 0, tpa 0A000001) launched 2 cycles after the reply's eop.
- Retry/fail: res_req, never res_done -> 3 request frames, each spaced 100 cycles after the prior eop; res_fail pulses 100 cycles after the 3rd eop; res_busy=0 afterward.
- Resolve success: res_done 50 cycles after the first eop -> no retransmission and no res_fail; a new res_req is accepted next.
- Overwrite/ignore: two rep_req pulses (ip A then B) while a request frame is in WAIT -> only the reply to B is sent. A second res_req while res_busy -> ignored, and tx_tpa remains the first IP.
- Reset mid-frame: assert rst_n low in WAIT -> all outputs return to reset values; no tx_start after release until a new request.
